// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: per-register countdowns for in-flight load and load-multiple destinations.
// Optional stall statistics counter enabled by defining HAZ_STATS_EN.
module hazard_scoreboard #(
    parameter int NREG     = 8,
    parameter int REG_W    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 4,
    parameter int PC_REG   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src_a,
    input  logic             id_src_a_use,
    input  logic [REG_W-1:0] id_src_b,
    input  logic             id_src_b_use,
    input  logic             ld_issue,
    input  logic [REG_W-1:0] ld_dest,
    input  logic             lm_issue,
    input  logic [NREG-1:0]  lm_mask,
    input  logic             flush,
    output logic             stall,
    output logic [NREG-1:0]  pend_vec,
    output logic [15:0]      stall_count
);

    localparam logic [CNT_W-1:0] LD_NEW = CNT_W'(LOAD_LAT - 1);

    logic [CNT_W-1:0] cnt      [NREG];
    logic [CNT_W-1:0] cnt_next [NREG];
    logic [NREG-1:0]  issue_vec;
    logic [NREG-1:0]  live_vec;

    // NOTE: always_comb uses blocking assignments and gives every output a default
    // first, so each loop pass sees up-to-date values and no latch is inferred.
    always_comb begin
        logic [CNT_W-1:0] dec;
        logic [CNT_W-1:0] nv;
        logic [CNT_W-1:0] lm_v;
        int               rank;
        rank = 0;
        for (int i = 0; i < NREG; i++) begin
            dec  = (cnt[i] != '0) ? cnt[i] - 1'b1 : '0;
            nv   = '0;
            lm_v = CNT_W'(LOAD_LAT - 1 + rank);
            if (ld_issue && ld_dest == REG_W'(i))
                nv = LD_NEW;
            if (lm_issue && lm_mask[i] && lm_v > nv)
                nv = lm_v;
            if (lm_mask[i])
                rank = rank + 1;
            cnt_next[i] = (dec > nv) ? dec : nv;
            if (i == PC_REG)
                cnt_next[i] = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; these counters are control
    // state (not a data memory), so they are all cleared on reset and on flush.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (reset || flush)
                cnt[i] <= '0;
            else
                cnt[i] <= cnt_next[i];
        end
    end

    // Same-cycle issue terms give the zero-latency stall for a consumer right behind a load.
    always_comb begin
        issue_vec = '0;
        pend_vec  = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_vec[i]  = (cnt[i] != '0);
            issue_vec[i] = (ld_issue && ld_dest == REG_W'(i)) || (lm_issue && lm_mask[i]);
        end
        live_vec         = pend_vec | issue_vec;
        live_vec[PC_REG] = 1'b0;
    end

    assign stall = id_valid && !flush && !reset &&
                   ((id_src_a_use && live_vec[id_src_a]) ||
                    (id_src_b_use && live_vec[id_src_b]));

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= 16'h0000;
        else if (stall && stall_count != 16'hFFFF)
            stall_count <= stall_count + 16'h0001;
    end
`else
    assign stall_count = 16'h0000;
`endif

endmodule
